// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter slice.
//   tx_state_e  : frame sequencer states
//   TX_STATE_W  : width of the state encoding
//   PAR_EVEN/PAR_ODD : encodings of the PAR_TYP input
package uart_tx_pkg;

    localparam int TX_STATE_W = 3;

    typedef enum logic [TX_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// and the level is a plain pointer difference.
//   clk_i, rst_ni         : clock, async active-low reset (flushes pointers)
//   wr_en_i, wr_data_i    : write request; ignored while full
//   rd_en_i, rd_data_o    : read request; rd_data_o shows the head word
//   full_o, empty_o       : status
//   level_o               : words currently stored
module uart_tx_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          push;
    logic          pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// Parametrised UART transmitter with input FIFO.
// Words enter through DATA_VALID/READY, are serialised LSB-first as
// start, DATA_WIDTH data bits, optional parity, 1 or 2 stop bits, one bit
// per TICK period.  Frame config is latched when a word is popped.
// Optional feature macro: UART_TX_PARITY_EN (parity bit support).  When it
// is undefined PAR_EN/PAR_TYP are ignored and no parity bit is ever sent.
//   CLK, RST                 : clock, async active-low reset
//   TICK                     : baud strobe
//   P_DATA, DATA_VALID, READY: push handshake
//   PAR_EN, PAR_TYP, STOP2   : frame configuration
//   TX_OUT                   : serial line (idles high)
//   BUSY                     : frame in progress
//   FIFO_LEVEL               : words queued
//
// state     | meaning
// ST_IDLE   | line high, waiting for a TICK with data queued
// ST_START  | start bit on the line
// ST_DATA   | data bits on the line
// ST_PARITY | parity bit on the line
// ST_STOP1  | first stop bit
// ST_STOP2  | second stop bit
module uart_tx_fifo_top
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          TICK,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          DATA_VALID,
    output logic                          READY,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    output logic                          TX_OUT,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    tx_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic                   busy_q;
    logic                   stop2_q, stop2_d;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   frame_end;

`ifdef UART_TX_PARITY_EN
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
`else
    logic                   unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    uart_tx_sync_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .wr_en_i   (DATA_VALID),
        .wr_data_i (P_DATA),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (FIFO_LEVEL)
    );

    assign READY  = !fifo_full;
    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        stop2_d   = stop2_q;
        fifo_pop  = 1'b0;
        frame_end = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        if (TICK) begin
            unique case (state_q)
                ST_IDLE: tx_d = 1'b1;
                ST_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH-1)) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP1;
                        end
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP1;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP1;
                end
`endif
                ST_STOP1: begin
                    if (stop2_q) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP2;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                ST_STOP2: frame_end = 1'b1;
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase

            if (frame_end) begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end

            // Pop from idle or straight out of the last stop bit, so queued
            // words go out back-to-back without an idle bit.
            if ((state_q == ST_IDLE || frame_end) && !fifo_empty) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_rd_data;
                stop2_d  = STOP2;
                tx_d     = 1'b0;
                state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
                par_en_d  = PAR_EN;
                par_bit_d = (^fifo_rd_data) ^ (PAR_TYP == PAR_ODD);
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != ST_IDLE);
            stop2_q   <= stop2_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
`endif

endmodule

// File: doc/uart_tx_fifo_top.md
# uart_tx_fifo_top

Parametrised UART transmitter: next generation of the team's fixed 8-bit TX top. Accepts parallel words through a valid/ready handshake into an internal FIFO. Serialises each word LSB-first as a frame of start bit, DATA_WIDTH data bits, optional even/odd parity and 1 or 2 stop bits, paced by an external baud strobe. Sits between the register-file/system controller and the TX pad.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal 5..9.
- FIFO_DEPTH, 4: words of buffering; power of two, ≥2.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- TICK  in  1  baud strobe, one CLK wide; each frame bit lasts exactly one TICK period.
- P_DATA  in  DATA_WIDTH  word to transmit.
- DATA_VALID  in  1  P_DATA valid this cycle.
- READY  out  1  FIFO can accept a word (level < FIFO_DEPTH); combinational from level register.
- PAR_EN  in  1  1 = parity bit appended.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits.
- TX_OUT  out  1  serial line, registered, idles high.
- BUSY  out  1  frame in progress (state ≠ IDLE), registered.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  words currently queued.

## Operation
- Push: DATA_VALID & READY at a rising edge writes P_DATA; DATA_VALID while READY=0 is ignored (word dropped, no state change).
- Push and pop in the same cycle: level unchanged, both take effect.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2; all transitions occur only on cycles with TICK=1.
- IDLE: TX_OUT=1. On TICK with level>0: pop word into shift register, latch PAR_EN/PAR_TYP/STOP2 into frame config, TX_OUT<=0, go START.
- START -> DATA on TICK, TX_OUT<=bit0; bit counter cleared.
- DATA: on each TICK shift, TX_OUT<=next bit; after bit DATA_WIDTH-1 go PARITY if latched PAR_EN else STOP1.
- PARITY: TX_OUT = ^data (even) or ~^data (odd), computed from popped word; -> STOP1 on TICK.
- STOP1: TX_OUT=1; on TICK -> STOP2 if latched STOP2, else end of frame.
- STOP2: TX_OUT=1; on TICK -> end of frame.
- End of frame: if level>0, pop and go START in the same cycle (back-to-back, no idle bit); else IDLE.
- Config inputs changed mid-frame affect only the next frame.
- Reset (asynchronous, any time incl. mid-frame): state IDLE, TX_OUT=1, BUSY=0, FIFO flushed, FIFO_LEVEL=0, READY=1, shift register and config cleared.

## Timing
- Push at edge n: FIFO_LEVEL updates at n+1.
- Pop on first TICK edge t with level>0: TX_OUT low and BUSY high from t+1.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) TICK periods.
- BUSY falls at the edge of the final stop bit's closing TICK unless a back-to-back pop occurs (then stays high).
- READY falls the cycle after the push that fills the FIFO; rises the cycle after the pop that frees a slot.
- TICK absent: state, TX_OUT and FIFO contents hold indefinitely.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity logic present; behaviour as above.
- Undefined: parity hardware removed; PAR_EN, PAR_TYP ignored; frames never carry a parity bit; ports remain for pin compatibility.

## Structure
- Package uart_tx_pkg: state enum typedef, PAR_EVEN/PAR_ODD constants, state width constant.
- Sub-module uart_tx_sync_fifo: synchronous FIFO, read/write pointers with extra wrap bit, full/empty/level outputs; top contains FSM, shift register, bit counter, parity.

## Test plan
- Reset: hold RST low 3 cycles, drop mid-frame -> TX_OUT=1, BUSY=0, FIFO_LEVEL=0, READY=1 immediately.
- Single frame, DATA_WIDTH=8, 0xA5, PAR_EN=0, STOP2=0, TICK every 4 cycles -> line 0,1,0,1,0,0,1,0,1,1 (10 bits, 4 cycles each), then IDLE.
- Parity: 0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; PAR_TYP=1 -> 0; STOP2=1 -> two stop bits, 12-bit frame.
- Back-to-back: push 0x11,0x22,0x33 in consecutive cycles -> three frames, no idle bit between, BUSY high throughout, FIFO_LEVEL 3->2->1->0.
- Full FIFO, FIFO_DEPTH=4: push 6 words with TICK=0 -> READY=0 after 4th, words 5–6 dropped, FIFO_LEVEL=4; only first 4 transmitted.
- Mid-frame config change: toggle PAR_EN during DATA -> current frame unchanged, next frame uses new setting; UART_TX_PARITY_EN undefined -> no parity bit regardless.
